// File: rtl/ntt_mdc_pkg.sv
// Shared types for the MDC NTT pipeline: feeder FSM state encoding and the
// bit-reverse helper used when the feeder is built for INTT input order.
package ntt_mdc_pkg;

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_FULL   = 2'd1,
        ST_STREAM = 2'd2,
        ST_DRAIN  = 2'd3
    } feeder_state_e;

    // Reverses the low w bits of v; bits at and above w come back as zero.
    function automatic logic [31:0] bitrev(input logic [31:0] v, input int w);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < w; i++) begin
            r[i] = v[w-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/ntt_mdc_feeder_if.sv
// Host-side and stage-side signal bundle of the MDC feeder.
// master = host / downstream observer, slave = the feeder itself.
interface ntt_mdc_feeder_if #(
    parameter int LOGQ = 64
);
    logic            in_valid;
    logic            in_ready;
    logic [LOGQ-1:0] in_data;
    logic            run;
    logic            busy;
    logic            done;
    logic            out_start;
    logic [LOGQ-1:0] out_0;
    logic [LOGQ-1:0] out_1;

    modport master (
        output in_valid, in_data, run,
        input  in_ready, busy, done, out_start, out_0, out_1
    );

    modport slave (
        input  in_valid, in_data, run,
        output in_ready, busy, done, out_start, out_0, out_1
    );
endinterface

// File: rtl/feeder_bank_ram.sv
// Simple dual-port coefficient bank; read data is valid DELAY_BRAM cycles
// after the read address is presented. Contents are never cleared.
module feeder_bank_ram #(
    parameter int LOGQ       = 64,
    parameter int AW         = 9,
    parameter int DELAY_BRAM = 2
) (
    input  logic            clk,
    input  logic            i_we,
    input  logic [AW-1:0]   i_waddr,
    input  logic [LOGQ-1:0] i_wdata,
    input  logic [AW-1:0]   i_raddr,
    output logic [LOGQ-1:0] o_rdata
);
    logic [LOGQ-1:0] r_mem  [2**AW];
    logic [LOGQ-1:0] r_pipe [DELAY_BRAM];

    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
        r_pipe[0] <= r_mem[i_raddr];
        for (int i = 1; i < DELAY_BRAM; i++) r_pipe[i] <= r_pipe[i-1];
    end

    assign o_rdata = r_pipe[DELAY_BRAM-1];
endmodule

// File: rtl/shiftreg.sv
// Synchronously-reset delay line, DEPTH register stages of WIDTH bits.
module shiftreg #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);
    logic [WIDTH-1:0] r_sr [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) r_sr[i] <= '0;
        end else begin
            r_sr[0] <= i_d;
            for (int i = 1; i < DEPTH; i++) r_sr[i] <= r_sr[i-1];
        end
    end

    assign o_q = r_sr[DEPTH-1];
endmodule

// File: rtl/ntt_mdc_feeder.sv
// Buffers one N-coefficient polynomial and streams it as two MDC lanes
// (coef[k], coef[k+N/2]). FEEDER_BITREV_EN selects bit-reversed write order.
//
//   state  | meaning
//   LOAD   | accepting host coefficients, wr_cnt = next index
//   FULL   | polynomial buffered, waiting for run
//   STREAM | issuing one read pair per cycle, rd_cnt = 0..N/2-1
//   DRAIN  | read pipeline emptying; done pulses on exit
module ntt_mdc_feeder
    import ntt_mdc_pkg::*;
#(
    parameter int LOGQ       = 64,
    parameter int LOGN       = 10,
    parameter int DELAY_BRAM = 2
) (
    input  logic               clk,
    input  logic               rst,
    ntt_mdc_feeder_if.slave    bus
);
    localparam int AW   = LOGN - 1;
    localparam int HALF = 2 ** AW;
    localparam int DW   = $clog2(DELAY_BRAM + 1);

    feeder_state_e   r_state, w_state_nxt;
    logic [LOGN-1:0] r_wr_cnt, w_wr_cnt_nxt;
    logic [AW-1:0]   r_rd_cnt, w_rd_cnt_nxt;
    logic [DW-1:0]   r_drain_cnt, w_drain_cnt_nxt;
    logic            r_done, w_done_nxt;
    logic            w_xfer;
    logic [LOGN-1:0] w_idx;
    logic            w_rd_issue;
    logic            w_pair_vld;
    logic [LOGQ-1:0] w_rdata0, w_rdata1;
    logic            r_out_start;
    logic [LOGQ-1:0] r_out_0, r_out_1;

    assign w_xfer = (r_state == ST_LOAD) && bus.in_valid;

`ifdef FEEDER_BITREV_EN
    assign w_idx = LOGN'(bitrev(32'(r_wr_cnt), LOGN));
`else
    assign w_idx = r_wr_cnt;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_LOAD;
            r_wr_cnt    <= '0;
            r_rd_cnt    <= '0;
            r_drain_cnt <= '0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_wr_cnt    <= w_wr_cnt_nxt;
            r_rd_cnt    <= w_rd_cnt_nxt;
            r_drain_cnt <= w_drain_cnt_nxt;
            r_done      <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_wr_cnt_nxt    = r_wr_cnt;
        w_rd_cnt_nxt    = r_rd_cnt;
        w_drain_cnt_nxt = r_drain_cnt;
        w_done_nxt      = 1'b0;
        case (r_state)
            ST_LOAD: begin
                if (w_xfer) begin
                    w_wr_cnt_nxt = r_wr_cnt + 1'b1;
                    if (r_wr_cnt == '1) w_state_nxt = ST_FULL;
                end
            end
            ST_FULL: begin
                if (bus.run) begin
                    w_state_nxt  = ST_STREAM;
                    w_rd_cnt_nxt = '0;
                end
            end
            ST_STREAM: begin
                w_rd_cnt_nxt = r_rd_cnt + 1'b1;
                if (r_rd_cnt == AW'(HALF - 1)) begin
                    w_state_nxt     = ST_DRAIN;
                    w_drain_cnt_nxt = DW'(DELAY_BRAM);
                end
            end
            ST_DRAIN: begin
                // Extra cycle beyond DELAY_BRAM covers the output register stage.
                if (r_drain_cnt == '0) begin
                    w_state_nxt  = ST_LOAD;
                    w_wr_cnt_nxt = '0;
                    w_done_nxt   = 1'b1;
                end else begin
                    w_drain_cnt_nxt = r_drain_cnt - 1'b1;
                end
            end
            default: w_state_nxt = ST_LOAD;
        endcase
    end

    feeder_bank_ram #(.LOGQ(LOGQ), .AW(AW), .DELAY_BRAM(DELAY_BRAM)) u_bank0 (
        .clk     (clk),
        .i_we    (w_xfer && !w_idx[LOGN-1]),
        .i_waddr (w_idx[AW-1:0]),
        .i_wdata (bus.in_data),
        .i_raddr (r_rd_cnt),
        .o_rdata (w_rdata0)
    );

    feeder_bank_ram #(.LOGQ(LOGQ), .AW(AW), .DELAY_BRAM(DELAY_BRAM)) u_bank1 (
        .clk     (clk),
        .i_we    (w_xfer && w_idx[LOGN-1]),
        .i_waddr (w_idx[AW-1:0]),
        .i_wdata (bus.in_data),
        .i_raddr (r_rd_cnt),
        .o_rdata (w_rdata1)
    );

    assign w_rd_issue = (r_state == ST_STREAM);

    shiftreg #(.WIDTH(1), .DEPTH(DELAY_BRAM)) u_vld_dly (
        .clk (clk),
        .rst (rst),
        .i_d (w_rd_issue),
        .o_q (w_pair_vld)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_start <= 1'b0;
            r_out_0     <= '0;
            r_out_1     <= '0;
        end else begin
            r_out_start <= w_pair_vld;
            r_out_0     <= w_pair_vld ? w_rdata0 : '0;
            r_out_1     <= w_pair_vld ? w_rdata1 : '0;
        end
    end

    assign bus.in_ready  = (r_state == ST_LOAD);
    assign bus.busy      = (r_state == ST_STREAM) || (r_state == ST_DRAIN);
    assign bus.done      = r_done;
    assign bus.out_start = r_out_start;
    assign bus.out_0     = r_out_0;
    assign bus.out_1     = r_out_1;
endmodule

// File: tb/tb_ntt_mdc_feeder.sv
// Directed bench for ntt_mdc_feeder at LOGN=4 (N=16); expected pair order
// follows FEEDER_BITREV_EN when it is defined for the build.
module tb_ntt_mdc_feeder;
    localparam int LOGQ = 16;
    localparam int LOGN = 4;
    localparam int N    = 16;
    localparam int H    = 8;
    localparam int D    = 2;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    // Bit-reversed 4-bit indices, written out by hand.
    int rev4 [16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};

    ntt_mdc_feeder_if #(.LOGQ(LOGQ)) bus_if ();

    ntt_mdc_feeder #(.LOGQ(LOGQ), .LOGN(LOGN), .DELAY_BRAM(D)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int lane_idx(input int k, input int lane);
        int j;
        j = k + lane * H;
`ifdef FEEDER_BITREV_EN
        return rev4[j];
`else
        return j;
`endif
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        bus_if.in_valid = 1'b0;
        bus_if.in_data  = '0;
        bus_if.run      = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        checks++;
        if (bus_if.in_ready !== 1'b1) begin
            failures++; $display("FAIL reset_in_ready got=%b exp=1", bus_if.in_ready);
        end
        checks++;
        if (bus_if.busy !== 1'b0 || bus_if.done !== 1'b0) begin
            failures++; $display("FAIL reset_busy_done got=%b%b exp=00", bus_if.busy, bus_if.done);
        end
        checks++;
        if (bus_if.out_start !== 1'b0 || bus_if.out_0 !== '0 || bus_if.out_1 !== '0) begin
            failures++;
            $display("FAIL reset_outputs got start=%b o0=%0d o1=%0d exp 0/0/0",
                     bus_if.out_start, bus_if.out_0, bus_if.out_1);
        end
    endtask

    task automatic load_frame(input int base, input int first, input int count);
        for (int i = 0; i < count; i++) begin
            bus_if.in_valid = 1'b1;
            bus_if.in_data  = LOGQ'(base + first + i);
            tick();
        end
        bus_if.in_valid = 1'b0;
    endtask

    // Issues run from FULL and checks every output cycle up to and including done.
    task automatic run_and_check(input int base, input bit hold_run, input string tag);
        logic            exp_vld;
        logic [LOGQ-1:0] exp0, exp1;
        checks++;
        if (bus_if.in_ready !== 1'b0) begin
            failures++; $display("FAIL %s full_in_ready got=%b exp=0", tag, bus_if.in_ready);
        end
        bus_if.run = 1'b1;
        tick();
        if (!hold_run) bus_if.run = 1'b0;
        checks++;
        if (bus_if.busy !== 1'b1) begin
            failures++; $display("FAIL %s busy_after_run got=%b exp=1", tag, bus_if.busy);
        end
        for (int c = 1; c <= H + D + 1; c++) begin
            tick();
            exp_vld = (c >= 1 + D) && (c <= D + H);
            exp0 = exp_vld ? LOGQ'(base + lane_idx(c - 1 - D, 0)) : '0;
            exp1 = exp_vld ? LOGQ'(base + lane_idx(c - 1 - D, 1)) : '0;
            checks++;
            if (bus_if.out_start !== exp_vld || bus_if.out_0 !== exp0 || bus_if.out_1 !== exp1) begin
                failures++;
                $display("FAIL %s pair c=%0d got start=%b (%0d,%0d) exp start=%b (%0d,%0d)",
                         tag, c, bus_if.out_start, bus_if.out_0, bus_if.out_1, exp_vld, exp0, exp1);
            end
            checks++;
            if (bus_if.done !== (c == H + D + 1) || bus_if.busy !== (c <= H + D)) begin
                failures++;
                $display("FAIL %s done_busy c=%0d got done=%b busy=%b exp done=%b busy=%b",
                         tag, c, bus_if.done, bus_if.busy, (c == H + D + 1), (c <= H + D));
            end
        end
        checks++;
        if (bus_if.in_ready !== 1'b1) begin
            failures++; $display("FAIL %s done_in_ready got=%b exp=1", tag, bus_if.in_ready);
        end
        bus_if.in_valid = 1'b0;
    endtask

    task automatic test_stream();
        load_frame(0, 0, N);
        run_and_check(0, 1'b0, "stream");
    endtask

    task automatic test_partial_and_stall();
        load_frame(200, 0, 10);
        bus_if.run = 1'b1;
        tick();
        bus_if.run = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            checks++;
            if (bus_if.busy !== 1'b0 || bus_if.out_start !== 1'b0 || bus_if.in_ready !== 1'b1) begin
                failures++;
                $display("FAIL partial_run c=%0d got busy=%b start=%b ready=%b exp 0/0/1",
                         c, bus_if.busy, bus_if.out_start, bus_if.in_ready);
            end
        end
        load_frame(200, 10, 6);
        bus_if.in_valid = 1'b1;
        bus_if.in_data  = LOGQ'(999);
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (bus_if.in_ready !== 1'b0 || bus_if.busy !== 1'b0) begin
                failures++;
                $display("FAIL full_stall c=%0d got ready=%b busy=%b exp 0/0",
                         c, bus_if.in_ready, bus_if.busy);
            end
        end
        // in_valid stays high through STREAM; run_and_check drops it at done.
        run_and_check(200, 1'b0, "partial");
    endtask

    task automatic test_reset_mid_stream();
        int c;
        load_frame(40, 0, N);
        bus_if.run = 1'b1;
        tick();
        bus_if.run = 1'b0;
        for (c = 1; c <= D + 3; c++) tick();
        checks++;
        if (bus_if.out_start !== 1'b1 || bus_if.out_0 !== LOGQ'(40 + lane_idx(2, 0))) begin
            failures++;
            $display("FAIL mid_third_pair got start=%b o0=%0d exp start=1 o0=%0d",
                     bus_if.out_start, bus_if.out_0, 40 + lane_idx(2, 0));
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (bus_if.out_start !== 1'b0 || bus_if.out_0 !== '0 || bus_if.out_1 !== '0 ||
            bus_if.busy !== 1'b0 || bus_if.in_ready !== 1'b1 || bus_if.done !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset got start=%b o0=%0d o1=%0d busy=%b ready=%b done=%b exp 0/0/0/0/1/0",
                     bus_if.out_start, bus_if.out_0, bus_if.out_1, bus_if.busy,
                     bus_if.in_ready, bus_if.done);
        end
        load_frame(100, 0, N);
        run_and_check(100, 1'b0, "after_reset");
    endtask

    task automatic test_back_to_back();
        load_frame(300, 0, N);
        run_and_check(300, 1'b1, "b2b_f1");
        load_frame(16, 0, N);
        run_and_check(16, 1'b1, "b2b_f2");
        bus_if.run = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_stream();
        test_partial_and_stall();
        test_reset_mid_stream();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule
